// File: rtl/eth_phy_10g_rx_gearbox.sv
// 32:66 receive gearbox: packs raw transceiver words LSB-first into 66-bit blocks
// (2-bit sync header + 64-bit payload) and implements bitslip as a one-bit discard.
module eth_phy_10g_rx_gearbox #(
    parameter int BIT_REVERSE = 0,
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int IN_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    input  logic                  bitslip,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic                  out_valid,
    output logic                  slip_done,
    output logic [6:0]            bit_count
);

    localparam int         BLOCK_W   = DATA_WIDTH + HDR_WIDTH;
    localparam int         BUF_W     = BLOCK_W + IN_WIDTH;
    localparam logic [6:0] BLOCK_CNT = 7'(BLOCK_W);
    localparam logic [6:0] IN_CNT    = 7'(IN_WIDTH);

    logic [BUF_W-1:0]    buf_q;
    logic [6:0]          cnt_q;
    logic                slip_pending;
    logic                bitslip_q;

    logic [IN_WIDTH-1:0] word;
    logic [BUF_W-1:0]    valid_mask;
    logic [BUF_W-1:0]    comb_bits;
    logic [6:0]          comb_cnt;
    logic                slip_rise;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        word = in_data;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                word[i] = in_data[IN_WIDTH-1-i];
            end
        end
    end

    // Append the new word above the buffered bits; a pending slip drops the oldest bit.
    always_comb begin
        valid_mask = (BUF_W'(1) << cnt_q) - BUF_W'(1);
        comb_bits  = (buf_q & valid_mask) | ({{(BUF_W-IN_WIDTH){1'b0}}, word} << cnt_q);
        comb_cnt   = cnt_q + IN_CNT;
        if (slip_pending) begin
            comb_bits = comb_bits >> 1;
            comb_cnt  = comb_cnt - 7'd1;
        end
    end

    assign slip_rise = bitslip & ~bitslip_q;
    assign bit_count = cnt_q;

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bit buffer is a plain register, and it is reset so partial blocks never survive a reset.
            buf_q        <= '0;
            cnt_q        <= '0;
            slip_pending <= 1'b0;
            bitslip_q    <= 1'b0;
            out_data     <= '0;
            out_hdr      <= '0;
            out_valid    <= 1'b0;
            slip_done    <= 1'b0;
        end else begin
            bitslip_q <= bitslip;
            out_valid <= 1'b0;
            slip_done <= 1'b0;

            if (in_valid) begin
                if (slip_pending) begin
                    slip_pending <= 1'b0;
                    slip_done    <= 1'b1;
                end
                if (comb_cnt >= BLOCK_CNT) begin
                    out_hdr   <= comb_bits[HDR_WIDTH-1:0];
                    out_data  <= comb_bits[BLOCK_W-1:HDR_WIDTH];
                    out_valid <= 1'b1;
                    buf_q     <= comb_bits >> BLOCK_W;
                    cnt_q     <= comb_cnt - BLOCK_CNT;
                end else begin
                    buf_q <= comb_bits;
                    cnt_q <= comb_cnt;
                end
            end

            // Only a fresh edge arms a slip, and only when none is outstanding.
            if (!slip_pending && slip_rise) begin
                slip_pending <= 1'b1;
            end
        end
    end

endmodule
